// File: rtl/background_ctrl_if.sv
// Bundles the frame/request inputs and the colour/score/status outputs of background_ctrl.
// Latency: none; this is only a bundle of wires.
// Backpressure: none; every signal is a level or a single-cycle pulse.
//
// Signals:
//   vblnk_in            vertical blanking level from the timing generator
//   start_btn           synchronized start button (level)
//   point_p1, point_p2  single-cycle "player scored" pulses
//   color1, color2      interior / line colour to the background drawer
//   score_p1, score_p2  current scores
//   game_state          0 IDLE, 1 PLAY, 2 FLASH, 3 OVER
//   play_en             high only in PLAY
//   frame_tick          one-cycle pulse per frame
interface background_ctrl_if;
    logic        vblnk_in;
    logic        start_btn;
    logic        point_p1;
    logic        point_p2;
    logic [11:0] color1;
    logic [11:0] color2;
    logic [3:0]  score_p1;
    logic [3:0]  score_p2;
    logic [1:0]  game_state;
    logic        play_en;
    logic        frame_tick;

    // master: the surrounding game/timing logic that feeds the controller
    modport master (
        output vblnk_in, start_btn, point_p1, point_p2,
        input  color1, color2, score_p1, score_p2, game_state, play_en, frame_tick
    );

    // slave: the controller itself
    modport slave (
        input  vblnk_in, start_btn, point_p1, point_p2,
        output color1, color2, score_p1, score_p2, game_state, play_en, frame_tick
    );
endinterface

// File: rtl/background_ctrl.sv
// PONG game-state controller: IDLE/PLAY/FLASH/OVER sequencing, scores and background colours.
// Latency: every visible change lands on the pclk edge after vblnk_in rises (inside blanking).
// Backpressure: none; requests are latched as pending flags and consumed at the next frame tick.
//
// Ports:
//   pclk      pixel clock, the only clock
//   rst       asynchronous, active-low reset
//   bus       background_ctrl_if.slave: vblnk_in/start_btn/point_p1/point_p2 in,
//             color1/color2/score_p1/score_p2/game_state/play_en/frame_tick out
module background_ctrl #(
    parameter int unsigned WIN_SCORE    = 9,
    parameter int unsigned FLASH_FRAMES = 30,
    parameter int unsigned FLASH_SHIFT  = 2,
    parameter logic [11:0] BG_COLOR     = 12'h000,
    parameter logic [11:0] LINE_COLOR   = 12'hFFF,
    parameter logic [11:0] IDLE_LINE    = 12'h888,
    parameter logic [11:0] FLASH_COLOR  = 12'h800,
    parameter logic [11:0] P1_WIN_COLOR = 12'h00F,
    parameter logic [11:0] P2_WIN_COLOR = 12'h0F0
) (
    input  logic                pclk,
    input  logic                rst,
    background_ctrl_if.slave    bus
);

    localparam logic [3:0] WIN_S      = 4'(WIN_SCORE);
    localparam logic [7:0] FLASH_LAST = 8'(FLASH_FRAMES - 1);
    localparam logic [2:0] SHIFT_IDX  = 3'(FLASH_SHIFT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PLAY  = 2'd1,
        S_FLASH = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    state_t      state_q,      state_d;
    logic        vblnk_q,      vblnk_d;
    logic        start_btn_q,  start_btn_d;
    logic        start_pend_q, start_pend_d;
    logic        p1_pend_q,    p1_pend_d;
    logic        p2_pend_q,    p2_pend_d;
    logic [3:0]  score_p1_q,   score_p1_d;
    logic [3:0]  score_p2_q,   score_p2_d;
    logic [7:0]  flash_cnt_q,  flash_cnt_d;
    logic        last_p2_q,    last_p2_d;
    logic [11:0] color1_q,     color1_d;
    logic [11:0] color2_q,     color2_d;
    logic        frame_tick_q, frame_tick_d;

    logic tick;
    logic start_rise;
    logic p1_set;
    logic p2_set;
    logic scorer_won;

    // Scores stop at WIN_SCORE, so a 4-bit counter can never wrap.
    function automatic logic [3:0] sat_inc(input logic [3:0] s);
        return (s >= WIN_S) ? s : s + 4'd1;
    endfunction

    // ------------------------------------------------------------------
    // Frame edge and request capture
    // ------------------------------------------------------------------
    always_comb begin
        vblnk_d      = bus.vblnk_in;
        start_btn_d  = bus.start_btn;
        tick         = bus.vblnk_in & ~vblnk_q;
        start_rise   = bus.start_btn & ~start_btn_q;
        frame_tick_d = tick;

        // Points only count while the ball is in play; on a same-cycle tie
        // player 1 takes the point and player 2's pulse is discarded.
        p1_set = bus.point_p1 & (state_q == S_PLAY);
        p2_set = bus.point_p2 & ~bus.point_p1 & (state_q == S_PLAY);

        // Every tick either consumes or discards all pending requests. A
        // request arriving on the tick cycle itself survives to the next frame.
        start_pend_d = (start_pend_q & ~tick) | start_rise;
        p1_pend_d    = (p1_pend_q    & ~tick) | p1_set;
        p2_pend_d    = (p2_pend_q    & ~tick) | p2_set;
    end

    // ------------------------------------------------------------------
    // Game FSM: next state, scores and flash counter
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        score_p1_d  = score_p1_q;
        score_p2_d  = score_p2_q;
        flash_cnt_d = flash_cnt_q;
        last_p2_d   = last_p2_q;
        scorer_won  = last_p2_q ? (score_p2_q == WIN_S) : (score_p1_q == WIN_S);

        if (tick) begin
            unique case (state_q)
                S_IDLE: begin
                    if (start_pend_q) begin
                        state_d    = S_PLAY;
                        score_p1_d = 4'd0;
                        score_p2_d = 4'd0;
                    end
                end
                S_PLAY: begin
                    if (p1_pend_q) begin
                        state_d     = S_FLASH;
                        score_p1_d  = sat_inc(score_p1_q);
                        flash_cnt_d = 8'd0;
                        last_p2_d   = 1'b0;
                    end else if (p2_pend_q) begin
                        state_d     = S_FLASH;
                        score_p2_d  = sat_inc(score_p2_q);
                        flash_cnt_d = 8'd0;
                        last_p2_d   = 1'b1;
                    end
                end
                S_FLASH: begin
                    flash_cnt_d = flash_cnt_q + 8'd1;
                    if (flash_cnt_q == FLASH_LAST) begin
                        state_d = scorer_won ? S_OVER : S_PLAY;
                    end
                end
                S_OVER: begin
                    if (start_pend_q) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Colours, decoded from the upcoming state so they switch together
    // with it. Between ticks the next state equals the current one, so the
    // registered colours hold steady for the whole visible frame.
    // ------------------------------------------------------------------
    always_comb begin
        color1_d = BG_COLOR;
        color2_d = LINE_COLOR;
        unique case (state_d)
            S_IDLE:  color2_d = IDLE_LINE;
            S_PLAY:  color1_d = BG_COLOR;
            S_FLASH: color1_d = flash_cnt_d[SHIFT_IDX] ? FLASH_COLOR : BG_COLOR;
            S_OVER:  color1_d = last_p2_d ? P2_WIN_COLOR : P1_WIN_COLOR;
            default: color2_d = IDLE_LINE;
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            vblnk_q      <= 1'b0;
            start_btn_q  <= 1'b0;
            start_pend_q <= 1'b0;
            p1_pend_q    <= 1'b0;
            p2_pend_q    <= 1'b0;
            score_p1_q   <= 4'd0;
            score_p2_q   <= 4'd0;
            flash_cnt_q  <= 8'd0;
            last_p2_q    <= 1'b0;
            color1_q     <= BG_COLOR;
            color2_q     <= IDLE_LINE;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            vblnk_q      <= vblnk_d;
            start_btn_q  <= start_btn_d;
            start_pend_q <= start_pend_d;
            p1_pend_q    <= p1_pend_d;
            p2_pend_q    <= p2_pend_d;
            score_p1_q   <= score_p1_d;
            score_p2_q   <= score_p2_d;
            flash_cnt_q  <= flash_cnt_d;
            last_p2_q    <= last_p2_d;
            color1_q     <= color1_d;
            color2_q     <= color2_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.color1     = color1_q;
    assign bus.color2     = color2_q;
    assign bus.score_p1   = score_p1_q;
    assign bus.score_p2   = score_p2_q;
    assign bus.game_state = state_q;
    assign bus.play_en    = (state_q == S_PLAY);
    assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_background_ctrl.sv
// Directed bench for background_ctrl (WIN_SCORE=2, FLASH_FRAMES=30, FLASH_SHIFT=2).
// Inputs are driven and outputs sampled on the falling edge of pclk.
// Every comparison goes through chk().
module tb_background_ctrl;

    logic pclk = 1'b0;
    logic rst  = 1'b0;
    always #5 pclk = ~pclk;

    background_ctrl_if ifc ();

    background_ctrl #(.WIN_SCORE(2)) dut (
        .pclk (pclk),
        .rst  (rst),
        .bus  (ifc)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int tick_cnt = 0;

    always @(negedge pclk) if (ifc.frame_tick) tick_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic expect_out(input string tag, input logic [1:0] st, input logic [11:0] c1,
                              input logic [11:0] c2, input logic [3:0] s1, input logic [3:0] s2);
        chk({tag, ".state"},   ifc.game_state, st);
        chk({tag, ".color1"},  ifc.color1,     c1);
        chk({tag, ".color2"},  ifc.color2,     c2);
        chk({tag, ".score1"},  ifc.score_p1,   s1);
        chk({tag, ".score2"},  ifc.score_p2,   s2);
        chk({tag, ".play_en"}, ifc.play_en,    (st == 2'd1));
    endtask

    // vblnk_in rises at a falling edge; the tick edge is the next rising edge.
    task automatic frame_begin();
        @(negedge pclk);
        ifc.vblnk_in = 1'b1;
    endtask

    task automatic frame_end();
        repeat (4) @(negedge pclk);
        ifc.vblnk_in = 1'b0;
        repeat (8) @(negedge pclk);
    endtask

    // One full frame; blanking is held high for several cycles and must
    // still produce exactly one frame_tick.
    task automatic frame();
        int t0;
        frame_begin();
        t0 = tick_cnt;
        frame_end();
        chk("ftick_per_frame", tick_cnt - t0, 1);
    endtask

    task automatic run_frames(input int n);
        for (int k = 0; k < n; k++) frame();
    endtask

    task automatic pulse(input logic p1, input logic p2, input logic st);
        @(negedge pclk);
        ifc.point_p1  = p1;
        ifc.point_p2  = p2;
        ifc.start_btn = st;
        @(negedge pclk);
        ifc.point_p1  = 1'b0;
        ifc.point_p2  = 1'b0;
        ifc.start_btn = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal;
    end

    initial begin
        ifc.vblnk_in  = 1'b0;
        ifc.start_btn = 1'b0;
        ifc.point_p1  = 1'b0;
        ifc.point_p2  = 1'b0;

        // Reset values
        repeat (3) @(negedge pclk);
        expect_out("reset", 2'd0, 12'h000, 12'h888, 4'd0, 4'd0);
        chk("reset.frame_tick", ifc.frame_tick, 1'b0);
        rst = 1'b1;

        // Idle frames with no input
        run_frames(3);
        expect_out("idle", 2'd0, 12'h000, 12'h888, 4'd0, 4'd0);

        // Start: change lands on the edge right after vblnk_in rises
        pulse(1'b0, 1'b0, 1'b1);
        frame_begin();
        chk("start.pre_edge_state", ifc.game_state, 2'd0);
        @(negedge pclk);
        expect_out("start", 2'd1, 12'h000, 12'hFFF, 4'd0, 4'd0);
        chk("start.frame_tick", ifc.frame_tick, 1'b1);
        frame_end();

        // Player 1 scores: flash pattern 000 x4, 800 x4, ...
        pulse(1'b1, 1'b0, 1'b0);
        frame();
        expect_out("flash0", 2'd2, 12'h000, 12'hFFF, 4'd1, 4'd0);
        for (int i = 1; i < 30; i++) begin
            frame();
            chk("flash.state", ifc.game_state, 2'd2);
            chk("flash.color1", ifc.color1, ((i / 4) % 2 == 1) ? 12'h800 : 12'h000);
        end
        frame();
        expect_out("flash_done", 2'd1, 12'h000, 12'hFFF, 4'd1, 4'd0);

        // Point pulse on the tick cycle: no effect this frame, counts next frame
        frame_begin();
        ifc.point_p2 = 1'b1;
        @(negedge pclk);
        ifc.point_p2 = 1'b0;
        chk("late_point.state", ifc.game_state, 2'd1);
        frame_end();
        frame();
        expect_out("late_point", 2'd2, 12'h000, 12'hFFF, 4'd1, 4'd1);
        run_frames(30);
        expect_out("late_point_done", 2'd1, 12'h000, 12'hFFF, 4'd1, 4'd1);

        // Simultaneous points: player 1 reaches 2 and wins, player 2 stays at 1
        pulse(1'b1, 1'b1, 1'b0);
        frame();
        expect_out("tie", 2'd2, 12'h000, 12'hFFF, 4'd2, 4'd1);
        run_frames(29);
        chk("tie.last_flash", ifc.game_state, 2'd2);
        frame();
        expect_out("p1_over", 2'd3, 12'h00F, 12'hFFF, 4'd2, 4'd1);

        // OVER -> IDLE keeps scores, IDLE -> PLAY clears them
        pulse(1'b0, 1'b0, 1'b1);
        frame();
        expect_out("over_idle", 2'd0, 12'h000, 12'h888, 4'd2, 4'd1);
        pulse(1'b0, 1'b0, 1'b1);
        frame();
        expect_out("replay", 2'd1, 12'h000, 12'hFFF, 4'd0, 4'd0);

        // Start in PLAY is ignored
        pulse(1'b0, 1'b0, 1'b1);
        frame();
        expect_out("start_in_play", 2'd1, 12'h000, 12'hFFF, 4'd0, 4'd0);

        // Player 2 wins with two points
        pulse(1'b0, 1'b1, 1'b0);
        frame();
        expect_out("p2_first", 2'd2, 12'h000, 12'hFFF, 4'd0, 4'd1);
        run_frames(30);
        expect_out("p2_first_done", 2'd1, 12'h000, 12'hFFF, 4'd0, 4'd1);
        pulse(1'b0, 1'b1, 1'b0);
        frame();
        expect_out("p2_second", 2'd2, 12'h000, 12'hFFF, 4'd0, 4'd2);
        run_frames(30);
        expect_out("p2_over", 2'd3, 12'h0F0, 12'hFFF, 4'd0, 4'd2);
        pulse(1'b0, 1'b0, 1'b1);
        frame();
        expect_out("p2_idle", 2'd0, 12'h000, 12'h888, 4'd0, 4'd2);
        pulse(1'b0, 1'b0, 1'b1);
        frame();
        expect_out("p2_replay", 2'd1, 12'h000, 12'hFFF, 4'd0, 4'd0);

        // Reset in the middle of a flash (flash_cnt = 10)
        pulse(1'b1, 1'b0, 1'b0);
        frame();
        run_frames(10);
        expect_out("pre_reset", 2'd2, 12'h000, 12'hFFF, 4'd1, 4'd0);
        @(negedge pclk);
        rst = 1'b0;
        #1;
        expect_out("mid_reset", 2'd0, 12'h000, 12'h888, 4'd0, 4'd0);
        chk("mid_reset.frame_tick", ifc.frame_tick, 1'b0);
        @(negedge pclk);
        rst = 1'b1;
        pulse(1'b1, 1'b0, 1'b0);
        frame();
        expect_out("post_reset", 2'd0, 12'h000, 12'h888, 4'd0, 4'd0);
        frame();
        expect_out("post_reset2", 2'd0, 12'h000, 12'h888, 4'd0, 4'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
